// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader placed directly upstream of the processor's load port.
//   It consumes a valid/ready word stream of segment headers and payload
//   words. It fills instruction and data memory through the *_load write
//   ports, and it holds `loading` high so the processor mux selects these
//   signals.
//
//   Header word:
//       [31]           last segment of the session
//       [30]           target memory (0 = IM, 1 = DM)
//       [16+AW-1:16]   base word address
//       [AW-1:0]       length - 1 (1 .. 2^AW words)
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   start                     one-cycle request to open a load session
//   in_valid/in_data/in_ready stream input (handshake = in_valid & in_ready)
//   loading, busy, done       session status; done pulses as loading drops
//   im_*_load, dm_*_load      memory write ports (cen/wen/oen active-low)
//   word_count                payload words written this session, saturating
//
// state  | meaning
// IDLE   | waiting for start, stream not accepted
// HEADER | accepting a segment header
// DATA   | accepting payload, one registered write per handshake
// DRAIN  | final write on the memory port, stream closed
// FINISH | drop loading/busy, raise done for one cycle

module program_loader #(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     loading,
    output logic                     im_cen_load,
    output logic                     im_wen_load,
    output logic                     im_oen_load,
    output logic [ADDRESS_WIDTH-1:0] im_addr_load,
    output logic [DATA_WIDTH-1:0]    im_datain_load,
    output logic                     dm_cen_load,
    output logic                     dm_wen_load,
    output logic                     dm_oen_load,
    output logic [ADDRESS_WIDTH-1:0] dm_addr_load,
    output logic [DATA_WIDTH-1:0]    dm_datain_load,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              word_count
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        DATA   = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t          state;
    logic            seg_last;
    logic            seg_dm;
    logic [AW-1:0]   cur_addr;
    logic [AW-1:0]   remaining;
    logic            hs;

    // in_ready is a registered output, so the handshake is fully determined
    // by flop state plus in_valid.
    assign hs = in_valid && in_ready;

    // The loader only ever writes, so the output enables stay inactive.
    assign im_oen_load = 1'b1;
    assign dm_oen_load = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            seg_last       <= 1'b0;
            seg_dm         <= 1'b0;
            cur_addr       <= '0;
            remaining      <= '0;
            in_ready       <= 1'b0;
            loading        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            word_count     <= '0;
            im_cen_load    <= 1'b1;
            im_wen_load    <= 1'b1;
            im_addr_load   <= '0;
            im_datain_load <= '0;
            dm_cen_load    <= 1'b1;
            dm_wen_load    <= 1'b1;
            dm_addr_load   <= '0;
            dm_datain_load <= '0;
        end else begin
            // A write lasts exactly one cycle unless DATA re-arms it below.
            done        <= 1'b0;
            im_cen_load <= 1'b1;
            im_wen_load <= 1'b1;
            dm_cen_load <= 1'b1;
            dm_wen_load <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= HEADER;
                        loading    <= 1'b1;
                        busy       <= 1'b1;
                        word_count <= '0;
                        in_ready   <= 1'b1;
                    end
                end

                HEADER: begin
                    if (hs) begin
                        seg_last  <= in_data[31];
                        seg_dm    <= in_data[30];
                        cur_addr  <= in_data[16 +: AW];
                        remaining <= in_data[AW-1:0];
                        state     <= DATA;
                    end
                end

                DATA: begin
                    if (hs) begin
                        if (seg_dm) begin
                            dm_cen_load    <= 1'b0;
                            dm_wen_load    <= 1'b0;
                            dm_addr_load   <= cur_addr;
                            dm_datain_load <= in_data;
                        end else begin
                            im_cen_load    <= 1'b0;
                            im_wen_load    <= 1'b0;
                            im_addr_load   <= cur_addr;
                            im_datain_load <= in_data;
                        end
                        // Natural AW-bit overflow gives the 2^AW-1 -> 0 wrap.
                        cur_addr  <= cur_addr + ADDR_ONE;
                        remaining <= remaining - ADDR_ONE;
                        if (word_count != 16'hFFFF) begin
                            word_count <= word_count + 16'd1;
                        end
                        if (remaining == '0) begin
                            if (seg_last) begin
                                state    <= DRAIN;
                                in_ready <= 1'b0;
                            end else begin
                                state    <= HEADER;
                            end
                        end
                    end
                end

                DRAIN: begin
                    // The final write is on the port this cycle; the
                    // defaults above release the enables afterwards.
                    state <= FINISH;
                end

                FINISH: begin
                    loading <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        loading;
    logic        im_cen_load, im_wen_load, im_oen_load;
    logic [10:0] im_addr_load;
    logic [31:0] im_datain_load;
    logic        dm_cen_load, dm_wen_load, dm_oen_load;
    logic [10:0] dm_addr_load;
    logic [31:0] dm_datain_load;
    logic        busy;
    logic        done;
    logic [15:0] word_count;

    program_loader #(.ADDRESS_WIDTH(11), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .loading        (loading),
        .im_cen_load    (im_cen_load),
        .im_wen_load    (im_wen_load),
        .im_oen_load    (im_oen_load),
        .im_addr_load   (im_addr_load),
        .im_datain_load (im_datain_load),
        .dm_cen_load    (dm_cen_load),
        .dm_wen_load    (dm_wen_load),
        .dm_oen_load    (dm_oen_load),
        .dm_addr_load   (dm_addr_load),
        .dm_datain_load (dm_datain_load),
        .busy           (busy),
        .done           (done),
        .word_count     (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected memory writes, pushed at handshake time.
    typedef struct {
        bit          dm;
        logic [10:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t sbq[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("oen_high", {31'd0, im_oen_load & dm_oen_load}, 32'd1);
            chk("no_dual_cen", {31'd0, !im_cen_load && !dm_cen_load}, 32'd0);
            if (!im_cen_load || !dm_cen_load) begin
                if (sbq.size() == 0) begin
                    chk("spurious_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = sbq.pop_front();
                    chk("wr_target", {31'd0, !dm_cen_load}, {31'd0, e.dm});
                    chk("wr_wen", {31'd0, e.dm ? dm_wen_load : im_wen_load}, 32'd0);
                    chk("wr_addr", {21'd0, e.dm ? dm_addr_load : im_addr_load}, {21'd0, e.addr});
                    chk("wr_data", e.dm ? dm_datain_load : im_datain_load, e.data);
                    chk("wr_latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Present one word, wait (bounded) for acceptance, and for payload words
    // record the write it must produce one cycle after the handshake.
    task automatic send(input logic [31:0] w, input bit payload, input bit dm,
                        input logic [10:0] addr, input int idle);
        wr_t e;
        bit  ok;
        repeat (idle) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        e.dm   = dm;
        e.addr = addr;
        e.data = w;
        e.cyc  = cyc + 1;
        @(posedge clk);
        if (payload && ok) sbq.push_back(e);
        #1 in_valid = 1'b0;
        in_data = 32'h0;
    endtask

    task automatic finish_check(input int exp_wc);
        @(negedge clk);
        chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
        chk("drain_loading", {31'd0, loading}, 32'd1);
        chk("drain_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("finish_in_ready", {31'd0, in_ready}, 32'd0);
        chk("finish_loading", {31'd0, loading}, 32'd1);
        chk("finish_done", {31'd0, done}, 32'd0);
        chk("finish_cen", {30'd0, im_cen_load, dm_cen_load}, 32'd3);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_loading", {31'd0, loading}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
        chk("word_count", {16'd0, word_count}, exp_wc);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("sb_drained", sbq.size(), 32'd0);
    endtask

    typedef struct {
        logic [31:0] header;
        int          nwords;
        logic [31:0] data0;
        bit          exp_dm;
        int          exp_base;
        int          max_idle;
    } seg_t;

    initial begin
        seg_t tbl[5];
        int   wc;
        bit   in_session;

        // last, IM, base 0, 4 words
        tbl[0] = '{32'h8000_0003, 4, 32'h0000_00A0, 1'b0, 0,     0};
        // DM, base 0x10, 2 words, then IM base 0, 1 word (last)
        tbl[1] = '{32'h4010_0001, 2, 32'h0000_00D0, 1'b1, 'h10,  1};
        tbl[2] = '{32'h8000_0000, 1, 32'h1234_5678, 1'b0, 0,     0};
        // IM base 0x7FF, 3 words: wraps to 0x000, 0x001
        tbl[3] = '{32'h87FF_0002, 3, 32'h0000_00B0, 1'b0, 'h7FF, 0};
        // DM base 0x123, 6 words, ignored bits set, random valid gaps
        tbl[4] = '{32'hE123_F805, 6, 32'hCAFE_0000, 1'b1, 'h123, 3};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_loading", {31'd0, loading}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_word_count", {16'd0, word_count}, 32'd0);
        chk("rst_enables", {26'd0, im_cen_load, im_wen_load, im_oen_load,
                            dm_cen_load, dm_wen_load, dm_oen_load}, 32'h3F);
        chk("rst_addr", {10'd0, im_addr_load, dm_addr_load}, 32'd0);
        chk("rst_datain", im_datain_load | dm_datain_load, 32'd0);
        rst = 1'b0;

        // Stream traffic in IDLE must be refused.
        in_valid = 1'b1; in_data = 32'h8000_0000;
        repeat (3) begin
            @(negedge clk);
            chk("idle_refuse_ready", {31'd0, in_ready}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end
        in_valid = 1'b0; in_data = 32'h0;

        wc = 0;
        in_session = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!in_session) begin
                pulse_start();
                in_session = 1'b1;
                wc = 0;
                chk("start_busy", {30'd0, busy, loading}, 32'd3);
            end
            send(tbl[i].header, 1'b0, 1'b0, 11'd0, 0);
            for (int j = 0; j < tbl[i].nwords; j++) begin
                send(tbl[i].data0 + 32'(j), 1'b1, tbl[i].exp_dm,
                     11'(tbl[i].exp_base + j),
                     int'($urandom_range(0, tbl[i].max_idle)));
                wc++;
            end
            if (tbl[i].header[31]) begin
                finish_check(wc);
                in_session = 1'b0;
            end
        end

        // Reset in the middle of a DATA segment.
        pulse_start();
        send(32'h8000_0003, 1'b0, 1'b0, 11'd0, 0);
        send(32'h0000_0E00, 1'b1, 1'b0, 11'd0, 0);
        send(32'h0000_0E01, 1'b1, 1'b0, 11'd1, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_loading", {31'd0, loading}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_enables", {28'd0, im_cen_load, im_wen_load,
                              dm_cen_load, dm_wen_load}, 32'hF);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_done", {30'd0, done, busy}, 32'd0);
        end
        chk("abort_sb_empty", sbq.size(), 32'd0);
        pulse_start();
        send(32'h8000_0001, 1'b0, 1'b0, 11'd0, 0);
        send(32'h0000_0055, 1'b1, 1'b0, 11'd0, 0);
        send(32'h0000_0056, 1'b1, 1'b0, 11'd1, 0);
        finish_check(2);

        // start pulses while a session is running are ignored.
        pulse_start();
        pulse_start();
        send(32'hC020_0002, 1'b0, 1'b0, 11'd0, 0);
        send(32'h0000_7700, 1'b1, 1'b1, 11'h20, 0);
        pulse_start();
        send(32'h0000_7701, 1'b1, 1'b1, 11'h21, 0);
        send(32'h0000_7702, 1'b1, 1'b1, 11'h22, 1);
        finish_check(3);
        repeat (4) begin
            @(negedge clk);
            chk("single_done", {30'd0, done, busy}, 32'd0);
        end

        chk("final_sb_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
